// File: rtl/sc_control_unit.sv
// Multi-cycle control unit for a single-cycle-datapath CPU: fetch/decode/execute/writeback FSM
// driving registered datapath selects, a write strobe, the program counter and a halt flag.
module sc_control_unit #(
    parameter int DATAWIDTH_BUS                 = 8,
    parameter int DATAWIDTH_INSTR               = 16,
    parameter int DATAWIDTH_ALU_SELECTION       = 4,
    parameter int DATAWIDTH_DECODER_SELECTION   = 3,
    parameter int DATAWIDTH_MUX_SELECTION       = 3,
    parameter int DATAWIDTH_REGSHIFTER_SELECTION = 2
) (
    input  logic                                      SC_CONTROL_UNIT_CLOCK_50,
    input  logic                                      SC_CONTROL_UNIT_Reset_InLow,
    input  logic [DATAWIDTH_INSTR-1:0]                SC_CONTROL_UNIT_InstrWord_In,
    input  logic                                      SC_CONTROL_UNIT_InstrValid_In,
    input  logic                                      SC_CONTROL_UNIT_Zero_In,
    output logic [DATAWIDTH_BUS-1:0]                  SC_CONTROL_UNIT_PC_Out,
    output logic                                      SC_CONTROL_UNIT_InstrRequest_Out,
    output logic [DATAWIDTH_ALU_SELECTION-1:0]        SC_CONTROL_UNIT_ALUSel_Out,
    output logic [DATAWIDTH_DECODER_SELECTION-1:0]    SC_CONTROL_UNIT_DecoderSel_Out,
    output logic [DATAWIDTH_MUX_SELECTION-1:0]        SC_CONTROL_UNIT_MuxASel_Out,
    output logic [DATAWIDTH_MUX_SELECTION-1:0]        SC_CONTROL_UNIT_MuxBSel_Out,
    output logic [DATAWIDTH_REGSHIFTER_SELECTION-1:0] SC_CONTROL_UNIT_ShiftSel_Out,
    output logic                                      SC_CONTROL_UNIT_WriteEnable_Out,
    output logic                                      SC_CONTROL_UNIT_Halted_Out
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXECUTE,
        ST_WRITEBACK,
        ST_HALT
    } state_t;

    localparam logic [DATAWIDTH_ALU_SELECTION-1:0] OP_BZ   = 4'hE;
    localparam logic [DATAWIDTH_ALU_SELECTION-1:0] OP_HALT = 4'hF;

    state_t                                      state_q, state_d;
    logic [DATAWIDTH_INSTR-1:0]                  ir_q, ir_d;
    logic                                        z_q, z_d;
    logic [DATAWIDTH_BUS-1:0]                    pc_q, pc_d;
    logic                                        req_q, req_d;
    logic [DATAWIDTH_ALU_SELECTION-1:0]          alu_q, alu_d;
    logic [DATAWIDTH_DECODER_SELECTION-1:0]      dec_q, dec_d;
    logic [DATAWIDTH_MUX_SELECTION-1:0]          mua_q, mua_d;
    logic [DATAWIDTH_MUX_SELECTION-1:0]          mub_q, mub_d;
    logic [DATAWIDTH_REGSHIFTER_SELECTION-1:0]   sh_q, sh_d;
    logic                                        we_q, we_d;
    logic                                        halt_q, halt_d;

    logic [DATAWIDTH_ALU_SELECTION-1:0]          opcode;
    assign opcode = ir_q[15:12];

    always_ff @(posedge SC_CONTROL_UNIT_CLOCK_50 or negedge SC_CONTROL_UNIT_Reset_InLow) begin
        if (!SC_CONTROL_UNIT_Reset_InLow) begin
            state_q <= ST_IDLE;
            ir_q    <= '0;
            z_q     <= 1'b0;
            pc_q    <= '0;
            req_q   <= 1'b0;
            alu_q   <= '0;
            dec_q   <= '0;
            mua_q   <= '0;
            mub_q   <= '0;
            sh_q    <= '0;
            we_q    <= 1'b0;
            halt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            z_q     <= z_d;
            pc_q    <= pc_d;
            req_q   <= req_d;
            alu_q   <= alu_d;
            dec_q   <= dec_d;
            mua_q   <= mua_d;
            mub_q   <= mub_d;
            sh_q    <= sh_d;
            we_q    <= we_d;
            halt_q  <= halt_d;
        end
    end

    // Outputs are registered, so each branch sets what must be visible in the *next* state.
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        z_d     = z_q;
        pc_d    = pc_q;
        req_d   = req_q;
        alu_d   = alu_q;
        dec_d   = dec_q;
        mua_d   = mua_q;
        mub_d   = mub_q;
        sh_d    = sh_q;
        we_d    = 1'b0;
        halt_d  = halt_q;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
                req_d   = 1'b1;
            end
            ST_FETCH: begin
                req_d = 1'b1;
                if (SC_CONTROL_UNIT_InstrValid_In) begin
                    ir_d    = SC_CONTROL_UNIT_InstrWord_In;
                    req_d   = 1'b0;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                dec_d = ir_q[11:9];
                mua_d = ir_q[8:6];
                mub_d = ir_q[5:3];
                sh_d  = ir_q[2:1];
                if (opcode == OP_HALT) begin
                    halt_d  = 1'b1;
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_EXECUTE;
                end
            end
            ST_EXECUTE: begin
                if (opcode == OP_BZ) begin
                    pc_d    = z_q ? ir_q[7:0] : pc_q + 1'b1;
                    req_d   = 1'b1;
                    state_d = ST_FETCH;
                end else begin
                    alu_d   = opcode;
                    we_d    = 1'b1;
                    state_d = ST_WRITEBACK;
                end
            end
            ST_WRITEBACK: begin
                z_d     = SC_CONTROL_UNIT_Zero_In;
                pc_d    = pc_q + 1'b1;
                req_d   = 1'b1;
                state_d = ST_FETCH;
            end
            ST_HALT: begin
                halt_d = 1'b1;
                req_d  = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign SC_CONTROL_UNIT_PC_Out           = pc_q;
    assign SC_CONTROL_UNIT_InstrRequest_Out = req_q;
    assign SC_CONTROL_UNIT_ALUSel_Out       = alu_q;
    assign SC_CONTROL_UNIT_DecoderSel_Out   = dec_q;
    assign SC_CONTROL_UNIT_MuxASel_Out      = mua_q;
    assign SC_CONTROL_UNIT_MuxBSel_Out      = mub_q;
    assign SC_CONTROL_UNIT_ShiftSel_Out     = sh_q;
    assign SC_CONTROL_UNIT_WriteEnable_Out  = we_q;
    assign SC_CONTROL_UNIT_Halted_Out       = halt_q;

endmodule

// File: tb/tb_sc_control_unit.sv
// Bench for sc_control_unit: an instruction-level model (PC, Z, last ALU op) predicts every
// cycle of each fetched instruction; directed cases plus a randomized instruction stream.
module tb_sc_control_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] instr;
    logic        valid;
    logic        zero;
    logic [7:0]  pc;
    logic        req;
    logic [3:0]  alu;
    logic [2:0]  dec;
    logic [2:0]  ma;
    logic [2:0]  mb;
    logic [1:0]  sh;
    logic        we;
    logic        halted;

    int n_checks = 0;
    int n_fail   = 0;

    int       m_pc;
    bit       m_z;
    bit [3:0] m_alu;

    always #5 clk = ~clk;

    sc_control_unit #(
        .DATAWIDTH_BUS(8),
        .DATAWIDTH_INSTR(16),
        .DATAWIDTH_ALU_SELECTION(4),
        .DATAWIDTH_DECODER_SELECTION(3),
        .DATAWIDTH_MUX_SELECTION(3),
        .DATAWIDTH_REGSHIFTER_SELECTION(2)
    ) dut (
        .SC_CONTROL_UNIT_CLOCK_50(clk),
        .SC_CONTROL_UNIT_Reset_InLow(rst_n),
        .SC_CONTROL_UNIT_InstrWord_In(instr),
        .SC_CONTROL_UNIT_InstrValid_In(valid),
        .SC_CONTROL_UNIT_Zero_In(zero),
        .SC_CONTROL_UNIT_PC_Out(pc),
        .SC_CONTROL_UNIT_InstrRequest_Out(req),
        .SC_CONTROL_UNIT_ALUSel_Out(alu),
        .SC_CONTROL_UNIT_DecoderSel_Out(dec),
        .SC_CONTROL_UNIT_MuxASel_Out(ma),
        .SC_CONTROL_UNIT_MuxBSel_Out(mb),
        .SC_CONTROL_UNIT_ShiftSel_Out(sh),
        .SC_CONTROL_UNIT_WriteEnable_Out(we),
        .SC_CONTROL_UNIT_Halted_Out(halted)
    );

    // Wait (bounded) at negedges for the fetch request.
    task automatic wait_fetch(input string tag);
        int n = 0;
        while (req !== 1'b1 && n < 16) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (req !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_fetch_timeout: req=%b required 1 within 16 cycles", tag, req);
        end
    endtask

    // Runs one instruction through the DUT and checks each cycle against the model.
    task automatic exec_instr(input logic [15:0] w, input logic zin, input int gap, input bit noise);
        logic [3:0] op;
        int         exp_pc;
        op = w[15:12];
        wait_fetch("exec");
        n_checks++;
        if (pc !== m_pc[7:0]) begin
            n_fail++; $display("FAIL fetch_pc: pc=%h required %h", pc, m_pc[7:0]);
        end
        for (int i = 0; i < gap; i++) begin
            valid = 1'b0;
            @(negedge clk);
            n_checks++;
            if (req !== 1'b1 || pc !== m_pc[7:0]) begin
                n_fail++; $display("FAIL fetch_hold: req=%b pc=%h required 1 %h", req, pc, m_pc[7:0]);
            end
        end
        instr = w; valid = 1'b1; zero = ~zin;
        @(negedge clk);
        valid = noise; instr = 16'($urandom);
        n_checks++;
        if (req !== 1'b0 || we !== 1'b0) begin
            n_fail++; $display("FAIL decode_cycle: req=%b we=%b required 0 0", req, we);
        end
        @(negedge clk);
        n_checks++;
        if ({dec, ma, mb, sh} !== {w[11:9], w[8:6], w[5:3], w[2:1]}) begin
            n_fail++;
            $display("FAIL selects: dec=%0d ma=%0d mb=%0d sh=%0d required %0d %0d %0d %0d",
                     dec, ma, mb, sh, w[11:9], w[8:6], w[5:3], w[2:1]);
        end
        if (op == 4'hF) begin
            valid = 1'b0;
            n_checks++;
            if (halted !== 1'b1 || req !== 1'b0 || we !== 1'b0) begin
                n_fail++; $display("FAIL halt_enter: halted=%b req=%b we=%b required 1 0 0", halted, req, we);
            end
            return;
        end
        n_checks++;
        if (we !== 1'b0 || req !== 1'b0) begin
            n_fail++; $display("FAIL execute_cycle: we=%b req=%b required 0 0", we, req);
        end
        @(negedge clk);
        valid = 1'b0; zero = zin;
        if (op == 4'hE) begin
            exp_pc = m_z ? int'(w[7:0]) : (m_pc + 1) % 256;
            m_pc = exp_pc;
            n_checks++;
            if (we !== 1'b0 || req !== 1'b1 || pc !== m_pc[7:0]) begin
                n_fail++; $display("FAIL bz_result: we=%b req=%b pc=%h required 0 1 %h", we, req, pc, m_pc[7:0]);
            end
            return;
        end
        m_alu = op;
        n_checks++;
        if (we !== 1'b1 || alu !== m_alu || req !== 1'b0) begin
            n_fail++; $display("FAIL writeback: we=%b alu=%h req=%b required 1 %h 0", we, alu, req, m_alu);
        end
        @(negedge clk);
        zero = 1'($urandom);
        m_z  = zin;
        m_pc = (m_pc + 1) % 256;
        n_checks++;
        if (we !== 1'b0 || req !== 1'b1 || pc !== m_pc[7:0] || alu !== m_alu) begin
            n_fail++;
            $display("FAIL alu_done: we=%b req=%b pc=%h alu=%h required 0 1 %h %h", we, req, pc, alu, m_pc[7:0], m_alu);
        end
    endtask

    task automatic check_all_zero(input string tag);
        n_checks++;
        if ({pc, req, alu, dec, ma, mb, sh, we, halted} !== '0) begin
            n_fail++;
            $display("FAIL %s: pc=%h req=%b alu=%h dec=%0d ma=%0d mb=%0d sh=%0d we=%b halted=%b required all 0",
                     tag, pc, req, alu, dec, ma, mb, sh, we, halted);
        end
    endtask

    task automatic release_and_check_idle(input string tag);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (req !== 1'b0) begin
            n_fail++; $display("FAIL %s_idle: req=%b required 0", tag, req);
        end
        @(negedge clk);
        n_checks++;
        if (req !== 1'b1 || pc !== 8'h00) begin
            n_fail++; $display("FAIL %s_first_fetch: req=%b pc=%h required 1 00", tag, req, pc);
        end
        m_pc = 0; m_z = 1'b0; m_alu = 4'h0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; valid = 1'b0; zero = 1'b0; instr = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset_state");
        release_and_check_idle("reset");
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_checks++;
            if (req !== 1'b1 || pc !== 8'h00 || we !== 1'b0) begin
                n_fail++; $display("FAIL fetch_wait: req=%b pc=%h we=%b required 1 00 0", req, pc, we);
            end
        end
    endtask

    task automatic test_alu_directed();
        exec_instr(16'h3A4C, 1'b1, 0, 1'b0);
        n_checks++;
        if ({alu, dec, ma, mb, sh} !== {4'd3, 3'd5, 3'd1, 3'd1, 2'd2} || pc !== 8'h01) begin
            n_fail++;
            $display("FAIL alu_3a4c: alu=%0d dec=%0d ma=%0d mb=%0d sh=%0d pc=%h required 3 5 1 1 2 01",
                     alu, dec, ma, mb, sh, pc);
        end
    endtask

    task automatic test_bz();
        exec_instr(16'hE07F, 1'b0, 1, 1'b1);
        n_checks++;
        if (pc !== 8'h7F) begin
            n_fail++; $display("FAIL bz_taken: pc=%h required 7f", pc);
        end
        exec_instr(16'h1234, 1'b0, 0, 1'b0);
        exec_instr(16'hE07F, 1'b1, 2, 1'b0);
        n_checks++;
        if (pc !== 8'h81) begin
            n_fail++; $display("FAIL bz_not_taken: pc=%h required 81", pc);
        end
    endtask

    task automatic test_pc_wrap();
        exec_instr(16'h5555, 1'b1, 0, 1'b0);
        exec_instr(16'hE0FF, 1'b1, 0, 1'b0);
        exec_instr(16'h7FFE, 1'b0, 0, 1'b1);
        n_checks++;
        if (pc !== 8'h00) begin
            n_fail++; $display("FAIL pc_wrap: pc=%h required 00", pc);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            logic [15:0] w;
            w = 16'($urandom);
            w[15:12] = ($urandom_range(0, 3) == 0) ? 4'hE : 4'($urandom_range(0, 13));
            exec_instr(w, 1'($urandom), $urandom_range(0, 3), 1'($urandom));
        end
    endtask

    task automatic test_reset_mid();
        wait_fetch("mid_exec");
        instr = 16'h2A4C; valid = 1'b1;
        @(negedge clk); valid = 1'b1;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_all_zero("reset_in_execute");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (we !== 1'b0) begin
                n_fail++; $display("FAIL reset_no_we: we=%b required 0", we);
            end
        end
        valid = 1'b0;
        release_and_check_idle("after_exec_reset");
        exec_instr(16'h4111, 1'b1, 0, 1'b0);
        wait_fetch("mid_wb");
        instr = 16'h6222; valid = 1'b1;
        repeat (3) begin @(negedge clk); valid = 1'b0; end
        n_checks++;
        if (we !== 1'b1) begin
            n_fail++; $display("FAIL pre_wb_reset: we=%b required 1", we);
        end
        #2 rst_n = 1'b0;
        #1 check_all_zero("reset_in_writeback");
        release_and_check_idle("after_wb_reset");
    endtask

    task automatic test_halt();
        exec_instr(16'h9C00, 1'b0, 0, 1'b0);
        exec_instr(16'hF000, 1'b0, 0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            instr = 16'($urandom); valid = 1'($urandom);
            @(negedge clk);
            n_checks++;
            if (halted !== 1'b1 || req !== 1'b0 || we !== 1'b0 || pc !== m_pc[7:0] || alu !== m_alu) begin
                n_fail++;
                $display("FAIL halt_hold: halted=%b req=%b we=%b pc=%h alu=%h required 1 0 0 %h %h",
                         halted, req, we, pc, alu, m_pc[7:0], m_alu);
            end
        end
        #3 rst_n = 1'b0;
        #1 check_all_zero("halt_async_reset");
        valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_alu_directed();
        test_bz();
        test_pc_wrap();
        test_random();
        test_reset_mid();
        test_halt();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
